// File: rtl/screen_scanout.sv
// Screen buffer scan-out: walks screen memory in raster order and
// serializes each 16-bit word into a 1-bit pixel stream, LSB first.
module screen_scanout #(
  parameter int COLS_WORDS    = 32,
  parameter int ROWS          = 256,
  parameter int HBLANK_CYCLES = 0,
  parameter int VBLANK_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic        mem_rd,
  output logic [12:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic        pix_sof,
  output logic        pix_sol,
  output logic        pix_eol,
  output logic        frame_done,
  output logic        busy
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS_WORDS > 1) ? $clog2(COLS_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, STREAM, HBLANK, VBLANK
  } state_t;

  state_t        state, stateNext;
  logic [RW-1:0] row, rowNext;
  logic [CW-1:0] colWord, colNext;
  logic [3:0]    bitIdx, bitNext;
  logic [15:0]   blankCnt, blankNext;
  logic [15:0]   hold;
  logic [12:0]   addrHold, addrCalc;
  logic          doneNext;
  logic          accept, lastBit, lastCol, lastRow;

  assign addrCalc = 13'(32'(row) * COLS_WORDS + 32'(colWord));

  assign lastBit = (bitIdx == 4'd15);
  assign lastCol = (colWord == CW'(COLS_WORDS - 1));
  assign lastRow = (row == RW'(ROWS - 1));

  assign mem_rd    = (state == FETCH);
  assign mem_addr  = mem_rd ? addrCalc : addrHold;
  assign busy      = (state != IDLE);
  assign pix_valid = (state == STREAM);
  assign accept    = pix_valid & pix_ready;
  assign pix_data  = pix_valid & hold[bitIdx];
  assign pix_sof   = pix_valid & (row == '0) & (colWord == '0) & (bitIdx == 4'd0);
  assign pix_sol   = pix_valid & (colWord == '0) & (bitIdx == 4'd0);
  assign pix_eol   = pix_valid & lastCol & lastBit;

  always_comb begin
    stateNext = state;
    rowNext   = row;
    colNext   = colWord;
    bitNext   = bitIdx;
    blankNext = blankCnt;
    doneNext  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          stateNext = FETCH;
          rowNext   = '0;
          colNext   = '0;
        end
      end
      FETCH: stateNext = WAIT;
      WAIT: begin
        stateNext = STREAM;
        bitNext   = 4'd0;
      end
      STREAM: begin
        if (accept) begin
          if (!lastBit) begin
            bitNext = bitIdx + 4'd1;
          end else if (!lastCol) begin
            colNext   = colWord + CW'(1);
            stateNext = FETCH;
          end else if (!lastRow) begin
            colNext = '0;
            rowNext = row + RW'(1);
            if (HBLANK_CYCLES == 0) begin
              stateNext = FETCH;
            end else begin
              stateNext = HBLANK;
              blankNext = 16'(HBLANK_CYCLES);
            end
          end else begin
            colNext  = '0;
            rowNext  = '0;
            doneNext = 1'b1;
            // Zero-length vblank decides restart vs. idle right here
            if (VBLANK_CYCLES == 0) begin
              stateNext = enable ? FETCH : IDLE;
            end else begin
              stateNext = VBLANK;
              blankNext = 16'(VBLANK_CYCLES);
            end
          end
        end
      end
      HBLANK: begin
        blankNext = blankCnt - 16'd1;
        if (blankCnt == 16'd1) stateNext = FETCH;
      end
      VBLANK: begin
        blankNext = blankCnt - 16'd1;
        if (blankCnt == 16'd1) stateNext = enable ? FETCH : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      colWord    <= '0;
      bitIdx     <= '0;
      blankCnt   <= '0;
      hold       <= '0;
      addrHold   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= stateNext;
      row        <= rowNext;
      colWord    <= colNext;
      bitIdx     <= bitNext;
      blankCnt   <= blankNext;
      frame_done <= doneNext;
      if (state == WAIT) hold <= mem_rdata;
      if (state == FETCH) addrHold <= addrCalc;
    end
  end

endmodule
